uart_rx_word_packer: RTL
========================

UART_RX_WORD_PACKER -- requirements
Module: uart_rx_word_packer

Interface
REQ-001 Parameter TIMEOUT, default 100000, SHALL set the number of idle clock cycles after which a partially assembled word is discarded.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; all state is cleared while rst=0.
REQ-004 rx_byte  input  8  received byte from the UART receiver; valid only while rx_done=1.
REQ-005 rx_done  input  1  one-cycle pulse from the UART receiver marking a completed byte.
REQ-006 rx_ferr  input  1  framing-error qualifier; valid only while rx_done=1.
REQ-007 rd_ack  input  1  one-cycle pulse from the processor confirming it has consumed rx_word.
REQ-008 err_clr  input  1  one-cycle pulse that clears the sticky error flags.
REQ-009 rx_word  output  32  last completed word; the first received byte is in [31:24].
REQ-010 rx_valid  output  1  level; rx_word holds an unread word.
REQ-011 byte_cnt  output  2  number of bytes in the partial word (0-3).
REQ-012 overrun  output  1  sticky; a completed word was dropped.
REQ-013 frame_err  output  1  sticky; a byte arrived with a framing error.
REQ-014 to_err  output  1  sticky; a partial word timed out.

Function
REQ-015 FSM SHALL have 2 states: IDLE (byte_cnt=0) and COLLECT (byte_cnt 1-3).
- IDLE -> COLLECT on a good byte.
- COLLECT -> IDLE on word completion, frame error or timeout.
REQ-016 A good byte (rx_done=1, rx_ferr=0) SHALL update shift register to {shift[23:0], rx_byte} and increment byte_cnt modulo 4.
REQ-017 On the 4th good byte, the assembled word SHALL go to rx_word and byte_cnt SHALL wrap to 0, both visible 1 cycle after the edge sampling rx_done.
- rx_valid SHALL rise at the same time.
- Total latency: 1 cycle.
REQ-018 rd_ack while rx_valid=1 SHALL clear rx_valid on the next edge; rd_ack while rx_valid=0 SHALL be ignored.
REQ-019 Word completion with rx_valid=1 and no rd_ack in the same cycle:
- the new word SHALL be discarded;
- rx_word and rx_valid SHALL stay unchanged;
- overrun SHALL set.
REQ-020 Word completion in the same cycle as rd_ack SHALL load the new word, keep rx_valid=1 and not set overrun.
REQ-021 rx_done with rx_ferr=1 SHALL discard the byte and any partial word.
- byte_cnt SHALL go to 0 and the FSM to IDLE.
- frame_err SHALL set.
- rx_word and rx_valid SHALL be unaffected.
REQ-022 Idle counter: resets on every rx_done, counts every cycle in COLLECT, and holds at 0 in IDLE.
REQ-023 When the idle counter reaches TIMEOUT:
- the partial word SHALL be discarded and byte_cnt SHALL go to 0;
- the FSM SHALL return to IDLE;
- to_err SHALL set.
REQ-024 rx_done in the timeout cycle SHALL take priority: the byte is accepted and no timeout occurs.
REQ-025 err_clr SHALL clear overrun, frame_err and to_err; if a setting event occurs in the same cycle, set SHALL win.
REQ-026 The idle counter width SHALL be sufficient for TIMEOUT without wrap-around.

Reset
REQ-027 While rst=0, all outputs SHALL be 0:
- rx_word=32'h00000000, rx_valid=0, byte_cnt=0, overrun=0, frame_err=0, to_err=0;
- FSM=IDLE; shift register and idle counter = 0.
REQ-028 Reset asserted mid-word SHALL discard the partial word; after release, the next good byte SHALL be treated as byte 0 ([31:24]).

Verification
REQ-029 Bytes DE, AD, BE, EF -> rx_word=32'hDEADBEEF and rx_valid=1 one cycle after the 4th rx_done; byte_cnt=0.
REQ-030 Without rd_ack, bytes 01, 02, 03, 04 -> rx_word stays 32'hDEADBEEF and overrun=1.
- Then err_clr -> overrun=0.
REQ-031 rd_ack coincident with the 4th byte of 11, 22, 33, 44 -> rx_word=32'h11223344, rx_valid=1, overrun=0.
REQ-032 Sequence AA, BB, then a byte with rx_ferr=1, then 55, 66, 77, 88 -> byte_cnt=0 after the error, frame_err=1, rx_word=32'h55667788.
REQ-033 TIMEOUT=8; 3 bytes then 8 idle cycles -> byte_cnt=0, to_err=1.
- Separately, a byte arriving exactly in the 8th idle cycle -> accepted, byte_cnt=0 (word complete), to_err=0.
REQ-034 rst=0 pulse after 2 bytes -> all outputs 0.
- Then bytes CA, FE, BA, BE -> rx_word=32'hCAFEBABE.

Source files
------------

// File: rtl/uart_rx_word_packer.sv
// Packs bytes from a UART receiver into 32-bit words, first byte in the MSBs.
// A partial word is dropped on a framing error or after TIMEOUT idle cycles.
// A completed word that finds the previous one still unread is dropped and
// flagged as an overrun. All error flags are sticky until err_clr.
module uart_rx_word_packer #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_done,
    input  logic        rx_ferr,
    input  logic        rd_ack,
    input  logic        err_clr,
    output logic [31:0] rx_word,
    output logic        rx_valid,
    output logic [1:0]  byte_cnt,
    output logic        overrun,
    output logic        frame_err,
    output logic        to_err
);

    // Wide enough to hold TIMEOUT itself, so the counter can never wrap.
    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The edge that would take the counter to TIMEOUT is the timeout edge.
    localparam logic [CntW-1:0] TimeoutLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        StIdle,
        StCollect
    } state_e;

    state_e          state_q;
    logic [23:0]     shift_q;
    logic [CntW-1:0] idle_cnt_q;

    logic good_byte;
    logic bad_byte;
    logic word_done;
    logic word_load;
    logic word_drop;
    logic timeout_hit;

    // Decode this cycle's events; rx_done always beats the timeout.
    always_comb begin
        good_byte   = rx_done & ~rx_ferr;
        bad_byte    = rx_done & rx_ferr;
        word_done   = good_byte & (byte_cnt == 2'd3);
        word_load   = word_done & (~rx_valid | rd_ack);
        word_drop   = word_done & rx_valid & ~rd_ack;
        timeout_hit = (state_q == StCollect) & ~rx_done & (idle_cnt_q == TimeoutLast);
    end

    // Byte collection FSM with its shift register, byte count and idle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            shift_q    <= 24'h0;
            byte_cnt   <= 2'd0;
            idle_cnt_q <= '0;
        end else begin
            if (rx_done) begin
                idle_cnt_q <= '0;
            end else if (state_q == StCollect && !timeout_hit) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end else begin
                idle_cnt_q <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (good_byte) begin
                        shift_q  <= {shift_q[15:0], rx_byte};
                        byte_cnt <= 2'd1;
                        state_q  <= StCollect;
                    end
                end
                StCollect: begin
                    if (bad_byte || timeout_hit || word_done) begin
                        // Word finished or abandoned: start the next one clean.
                        shift_q  <= 24'h0;
                        byte_cnt <= 2'd0;
                        state_q  <= StIdle;
                    end else if (good_byte) begin
                        shift_q  <= {shift_q[15:0], rx_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    shift_q  <= 24'h0;
                    byte_cnt <= 2'd0;
                end
            endcase
        end
    end

    // Output word holding register and its unread flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_word  <= 32'h0;
            rx_valid <= 1'b0;
        end else if (word_load) begin
            rx_word  <= {shift_q, rx_byte};
            rx_valid <= 1'b1;
        end else if (rd_ack) begin
            rx_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            to_err    <= 1'b0;
        end else begin
            overrun   <= word_drop   | (overrun   & ~err_clr);
            frame_err <= bad_byte    | (frame_err & ~err_clr);
            to_err    <= timeout_hit | (to_err    & ~err_clr);
        end
    end

endmodule
